// File: rtl/qed_dup_queue.sv
// Instruction duplication unit for SQED: passes originals through while queueing them,
// then replays them as duplicates whose register fields are moved into the shadow half.
module qed_dup_queue #(
    parameter int          DEPTH      = 8,
    parameter int          REG_OFFSET = 16,
    parameter logic [31:0] NOP        = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [31:0]                  inst_i,
    input  logic                         exec_dup_i,
    input  logic                         stall_i,
    output logic                         inst_ready_o,
    output logic [31:0]                  inst_o,
    output logic                         vld_o,
    output logic                         dup_o,
    output logic                         unsup_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         qed_ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [AW-1:0] PTR_STEP   = AW'(1);
    localparam logic [4:0]    OFFSET     = 5'(REG_OFFSET);

    typedef enum logic {ORIG, DUP} state_t;

    state_t         state_reg, state_next;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [31:0]    inst_reg, inst_next;
    logic           vld_reg, vld_next;
    logic           dup_reg, dup_next;
    logic           unsup_reg, unsup_next;

    // Bit mask of fields to remap, ordered {rs2, rs1, rd}; zero means the opcode is unsupported.
    function automatic logic [2:0] remap_mask(input logic [6:0] opcode);
        case (opcode)
            7'b0110011:             remap_mask = 3'b111;
            7'b0010011, 7'b0000011: remap_mask = 3'b011;
            7'b0100011:             remap_mask = 3'b110;
            7'b0110111, 7'b0010111: remap_mask = 3'b001;
            default:                remap_mask = 3'b000;
        endcase
    endfunction

    logic [31:0]      head;
    logic [2:0]       head_mask;
    logic [2:0][4:0]  head_fields;
    logic [31:0]      head_remap;

    assign head      = mem[rd_ptr_reg];
    assign head_mask = remap_mask(head[6:0]);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            localparam int LSB = (gi == 0) ? 7 : ((gi == 1) ? 15 : 20);
            logic [4:0] field;
            assign field = head[LSB +: 5];
            // x0 must stay x0 so hard-wired zero reads/writes keep their meaning
            assign head_fields[gi] = (head_mask[gi] && field != 5'd0) ? field + OFFSET : field;
        end
    endgenerate

    assign head_remap = {head[31:25], head_fields[2], head_fields[1], head[14:12],
                         head_fields[0], head[6:0]};

    logic active, in_orig, dup_start, pop, last_pop, push, inst_supported;

    assign empty_o        = (count_reg == '0);
    assign full_o         = (count_reg == FULL_COUNT);
    assign count_o        = count_reg;
    assign active         = ena & ~stall_i;
    assign in_orig        = (state_reg == ORIG);
    assign dup_start      = active & in_orig & exec_dup_i & ~empty_o;
    assign inst_ready_o   = active & in_orig & ~full_o & ~dup_start;
    assign pop            = dup_start | (active & ~in_orig & ~empty_o);
    assign last_pop       = pop & (count_reg == ONE_COUNT);
    assign inst_supported = |remap_mask(inst_i[6:0]);
    assign push           = inst_ready_o & inst_supported;
    assign qed_ready_o    = in_orig & empty_o;

    assign inst_o  = inst_reg;
    assign vld_o   = vld_reg;
    assign dup_o   = dup_reg;
    assign unsup_o = unsup_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ORIG;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ORIG:    if (dup_start && !last_pop) state_next = DUP;
            DUP:     if (last_pop)               state_next = ORIG;
            default: state_next = ORIG;
        endcase
    end

    // Stall holds the visible instruction; only the unsupported pulse is forced low.
    always_comb begin
        inst_next  = inst_reg;
        vld_next   = vld_reg;
        dup_next   = dup_reg;
        unsup_next = 1'b0;
        if (!stall_i) begin
            if (!ena) begin
                inst_next = NOP;
                vld_next  = 1'b0;
                dup_next  = 1'b0;
            end else if (pop) begin
                inst_next = head_remap;
                vld_next  = 1'b1;
                dup_next  = 1'b1;
            end else if (inst_ready_o) begin
                inst_next  = inst_i;
                vld_next   = 1'b1;
                dup_next   = 1'b0;
                unsup_next = ~inst_supported;
            end else begin
                inst_next = NOP;
                vld_next  = 1'b0;
                dup_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_reg  <= NOP;
            vld_reg   <= 1'b0;
            dup_reg   <= 1'b0;
            unsup_reg <= 1'b0;
        end else begin
            inst_reg  <= inst_next;
            vld_reg   <= vld_next;
            dup_reg   <= dup_next;
            unsup_reg <= unsup_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_STEP;
            count_reg  <= count_reg + ONE_COUNT;
        end else if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_STEP;
            count_reg  <= count_reg - ONE_COUNT;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= inst_i;
    end

endmodule
